// File: rtl/ahb_sram_slv.sv
// AHB-Lite SRAM slave with programmable wait states, error responses and a byte-write mailbox.
// Single-cycle data phases use a synchronous read taken at the address-phase edge.
module ahb_sram_slv #(
  parameter int          DATA_W       = 64,
  parameter int          DEPTH        = 4096,
  parameter int          WAIT_STATES  = 0,
  parameter logic [31:0] MAILBOX_ADDR = 32'hD0580000
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic              HWRITE,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [3:0]        HPROT,
  input  logic              HREADY,
  input  logic [DATA_W-1:0] HWDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [DATA_W-1:0] HRDATA,
  output logic              mbox_wr,
  output logic [7:0]        mbox_data
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

  state_t             state_q;
  logic [2:0]         cnt_q;
  logic               hready_q, hresp_q, pend_q;
  logic [DATA_W-1:0]  hrdata_q, hrdata_d;
  logic               mbox_wr_q;
  logic [7:0]         mbox_data_q;
  logic [IDX_W-1:0]   idx_q;
  logic [OFF_W-1:0]   off_q;
  logic [2:0]         size_q;
  logic               write_q, mbox_q;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic [OFF_W-1:0]   a_off, size_mask;
  logic [IDX_W-1:0]   a_idx, rd_idx;
  logic               a_mbox, a_err, accept;
  logic               done, wr_now, mb_now, rd_zero, rd_wait, rd_mbox;
  logic [NB-1:0]      wmask;
  logic [DATA_W-1:0]  rd_word;

  // HBURST/HPROT carry no meaning for a flat SRAM; HTRANS[0] only separates NONSEQ from SEQ.
  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

  function automatic logic [NB-1:0] lane_mask(input logic [OFF_W-1:0] off, input logic [2:0] size);
    logic [NB-1:0] m;
    for (int b = 0; b < NB; b++)
      m[b] = (b >= int'(off)) && (b < int'(off) + (1 << size));
    return m;
  endfunction

  assign a_off     = HADDR[OFF_W-1:0];
  assign a_idx     = HADDR[OFF_W +: IDX_W];
  assign a_mbox    = (HADDR == MAILBOX_ADDR);
  assign size_mask = OFF_W'((1 << HSIZE) - 1);
  assign accept    = HSEL && HREADY && HTRANS[1] && (state_q == IDLE || state_q == ERR2);

  // NOTE: every path assigns a_err, so this stays combinational instead of inferring a latch.
  always_comb begin
    a_err = 1'b0;
    if (a_mbox)
      a_err = (HSIZE != 3'd0);
    else if (int'(HSIZE) > OFF_W)
      a_err = 1'b1;
    else
      a_err = ((a_off & size_mask) != '0);
  end

  // A data phase completes in the IDLE-with-pending cycle, whatever the wait-state count.
  assign done    = (state_q == IDLE) && pend_q;
  assign wr_now  = done && write_q && !mbox_q;
  assign mb_now  = done && write_q && mbox_q;
  assign wmask   = lane_mask(off_q, size_q);
  assign rd_zero = accept && !a_err && !HWRITE && (WAIT_STATES == 0);
  assign rd_wait = (state_q == WAIT) && (cnt_q == 3'd1) && !write_q;
  assign rd_idx  = rd_zero ? a_idx  : idx_q;
  assign rd_mbox = rd_zero ? a_mbox : mbox_q;

  // Write-first: a write retiring on this edge is merged into a read of the same word.
  always_comb begin
    rd_word = mem[rd_idx];
    if (wr_now && idx_q == rd_idx)
      for (int b = 0; b < NB; b++)
        if (wmask[b]) rd_word[b*8 +: 8] = HWDATA[b*8 +: 8];
    hrdata_d = rd_mbox ? '0 : rd_word;
  end

  // NOTE: the storage array has no reset term, keeping it mappable onto SRAM macros.
  always_ff @(posedge HCLK) begin
    if (wr_now)
      for (int b = 0; b < NB; b++)
        if (wmask[b]) mem[idx_q][b*8 +: 8] <= HWDATA[b*8 +: 8];
  end

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hready_q    <= 1'b1;
      hresp_q     <= 1'b0;
      pend_q      <= 1'b0;
      hrdata_q    <= '0;
      mbox_wr_q   <= 1'b0;
      mbox_data_q <= '0;
      idx_q       <= '0;
      off_q       <= '0;
      size_q      <= '0;
      write_q     <= 1'b0;
      mbox_q      <= 1'b0;
    end else begin
      mbox_wr_q <= 1'b0;
      if (mb_now) begin
        mbox_wr_q   <= 1'b1;
        mbox_data_q <= HWDATA[{off_q, 3'b000} +: 8];
      end
      if (rd_zero || rd_wait) hrdata_q <= hrdata_d;

      case (state_q)
        IDLE, ERR2: begin
          state_q  <= IDLE;
          pend_q   <= 1'b0;
          hready_q <= 1'b1;
          hresp_q  <= 1'b0;
          if (accept) begin
            idx_q   <= a_idx;
            off_q   <= a_off;
            size_q  <= HSIZE;
            write_q <= HWRITE;
            mbox_q  <= a_mbox;
            if (a_err) begin
              state_q  <= ERR1;
              hready_q <= 1'b0;
              hresp_q  <= 1'b1;
            end else if (WAIT_STATES == 0) begin
              pend_q <= 1'b1;
            end else begin
              state_q  <= WAIT;
              cnt_q    <= 3'(WAIT_STATES);
              hready_q <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 3'd1) begin
            cnt_q    <= '0;
            state_q  <= IDLE;
            pend_q   <= 1'b1;
            hready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ERR1: begin
          state_q  <= ERR2;
          hready_q <= 1'b1;
          hresp_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign HREADYOUT = hready_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;
  assign mbox_wr   = mbox_wr_q;
  assign mbox_data = mbox_data_q;

endmodule
